arm_fetch_unit: RTL and testbench

ARM-state instruction fetch stage that sits directly upstream of the ALU/instruction decode stage.
- Keeps the fetch PC and issues word reads to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small prefetch FIFO and presents {instruction, PC, PC+8} to decode over a valid/ready handshake.
- On a branch it flushes the FIFO and discards stale in-flight responses.

---
 rtl/arm_fetch_pkg.sv | 23 ++
 rtl/arm_fetch_unit_buf.sv | 56 +++++
 rtl/arm_fetch_unit.sv | 108 ++++++++++
 tb/tb_arm_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the ARM-state fetch stage.
package arm_fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  localparam int          INSTR_W  = 32;
  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [31:0] PC_AHEAD = 32'd8;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/arm_fetch_unit_buf.sv
// Prefetch FIFO of {pc, instr}; clear beats push and pop, head is read combinationally.
module fetch_buf
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  fetch_entry_t            i_wdata,
  output fetch_entry_t            o_rdata,
  output logic [cnt_w(DEPTH)-1:0] o_count,
  output logic                    o_empty,
  output logic                    o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst || i_clear)
    !(i_push && o_full && !i_pop));

endmodule

// File: rtl/arm_fetch_unit.sv
// ARM-state fetch stage: issues word fetches, buffers in-order responses, hands
// {instr, pc, pc+8} to decode and redirects on branch.
module arm_fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [31:0]  imem_addr,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  input  logic         branch_valid,
  input  logic [31:0]  branch_target,
  input  logic         halt,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [31:0]  instr_data,
  output logic [31:0]  instr_pc,
  output logic [31:0]  instr_pc8,
  output fetch_state_e dbg_state
);

  localparam int CW = cnt_w(DEPTH);

  // Handshakes: a transfer happens on a cycle with valid && ready; a raised
  // valid and its payload stay put until that transfer, except on branch/rst.
  fetch_state_e  r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop;
  logic          r_req_pend;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_occupancy;
  logic [31:0]   w_target;
  logic          w_empty, w_full, w_room, w_accept, w_push, w_pop;
  fetch_entry_t  w_head, w_wdata;

  assign w_target    = branch_target & ~32'd3;
  assign w_pop       = !w_empty && instr_ready && !branch_valid;
  // Slots in use after this cycle's pop; stale in-flight fetches still hold a slot.
  assign w_occupancy = w_count + r_outst - CW'(w_pop);
  assign w_room      = (w_occupancy < CW'(DEPTH));

  assign imem_req_valid = (r_state == S_RUN) && !branch_valid && (r_req_pend || w_room);
  assign imem_addr      = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_push         = imem_rsp_valid && !branch_valid && (r_drop == '0);
  assign w_wdata        = '{pc: r_rsp_pc, instr: imem_rsp_data};

  fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clear (branch_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_outst    <= '0;
      r_drop     <= '0;
      r_req_pend <= 1'b0;
    end else begin
      if (branch_valid) begin
        r_pc       <= w_target;
        r_rsp_pc   <= w_target;
        r_outst    <= r_outst - CW'(imem_rsp_valid);
        r_drop     <= r_outst - CW'(imem_rsp_valid);
        r_req_pend <= 1'b0;
      end else begin
        if (w_accept) r_pc     <= r_pc + PC_INC;
        if (w_push)   r_rsp_pc <= r_rsp_pc + PC_INC;
        r_outst    <= r_outst + CW'(w_accept) - CW'(imem_rsp_valid);
        if (imem_rsp_valid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        r_req_pend <= imem_req_valid && !imem_req_ready;
      end
      case (r_state)
        S_BOOT:  r_state <= S_RUN;
        S_RUN:   if (halt && !(imem_req_valid && !imem_req_ready)) r_state <= S_HALT;
        S_HALT:  if (!halt) r_state <= S_RUN;
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign instr_valid = !w_empty;
  assign instr_data  = w_empty ? '0 : w_head.instr;
  assign instr_pc    = w_empty ? '0 : w_head.pc;
  assign instr_pc8   = instr_pc + PC_AHEAD;
  assign dbg_state   = r_state;

  a_slot_bound: assert property (@(posedge clk) disable iff (rst)
    !(w_full && (r_outst != '0)));

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Bench for arm_fetch_unit: reactive memory, randomized decode/branch/halt traffic,
// and a PC-stream scoreboard for the instructions reaching decode.
module tb_arm_fetch_unit;
  import arm_fetch_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0]  imem_addr, imem_rsp_data;
  logic         branch_valid, halt, instr_valid, instr_ready;
  logic [31:0]  branch_target, instr_data, instr_pc, instr_pc8;
  fetch_state_e dbg_state;

  logic         w2_req_valid, w2_rsp_valid, w2_instr_valid;
  logic [31:0]  w2_addr, w2_rsp_data, w2_data, w2_pc, w2_pc8;
  fetch_state_e w2_state;

  arm_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .branch_valid(branch_valid), .branch_target(branch_target), .halt(halt),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_pc8(instr_pc8), .dbg_state(dbg_state)
  );

  arm_fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w2_req_valid), .imem_req_ready(1'b1), .imem_addr(w2_addr),
    .imem_rsp_valid(w2_rsp_valid), .imem_rsp_data(w2_rsp_data),
    .branch_valid(1'b0), .branch_target(32'h0), .halt(1'b0),
    .instr_valid(w2_instr_valid), .instr_ready(1'b1), .instr_data(w2_data),
    .instr_pc(w2_pc), .instr_pc8(w2_pc8), .dbg_state(w2_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_gen, exp_fetch;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend_q[$];
  int cyc = 0, lat_extra = 0, lat_rand = 0;
  int hs_count = 0, acc_count = 0, acc_epoch = 0, hs_epoch = 0, br_pend = -1, wrap_checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Decode must see a sequential PC stream starting at the last reset/branch target.
  function automatic void model_restart(input logic [31:0] pc);
    exp_q.delete();
    exp_gen   = pc;
    exp_fetch = pc;
    acc_epoch = 0;
    hs_epoch  = 0;
    repeat (4) begin
      exp_q.push_back(exp_gen);
      exp_gen += 32'd4;
    end
  endfunction

  // ---------------- instruction memory model ----------------
  initial begin
    int extra;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
      #3;
      if (rst) pend_q.delete();
      else begin
        if (branch_valid) br_pend = pend_q.size() + (imem_rsp_valid ? 1 : 0);
        if (imem_req_valid && imem_req_ready) begin
          extra = lat_rand ? int'($urandom_range(0, 3)) : lat_extra;
          pend_q.push_back('{addr: imem_addr, due: cyc + 1 + extra});
        end
        checks++;
        if (pend_q.size() > DEPTH) begin
          failures++;
          $display("FAIL outstanding_bound: got %0d expected <= %0d", pend_q.size(), DEPTH);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev_br, prev_rst, prev_req_wait;
    prev_br = 1'b0; prev_rst = 1'b1; prev_req_wait = 1'b0;
    model_restart(RESET_PC);
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        model_restart(RESET_PC);
        prev_rst = 1'b1; prev_br = 1'b0; prev_req_wait = 1'b0;
      end else begin
        if (prev_br || prev_rst) check32("valid_after_flush", 32'(instr_valid), 32'd0);
        if (prev_req_wait && !branch_valid) check32("req_hold", 32'(imem_req_valid), 32'd1);
        if (instr_valid) begin
          check32("head_pc", instr_pc, exp_q[0]);
          check32("head_pc8", instr_pc8, exp_q[0] + 32'd8);
          check32("head_data", instr_data, mem_word(exp_q[0]));
        end
        if (branch_valid) begin
          check32("no_req_in_branch", 32'(imem_req_valid), 32'd0);
          model_restart(branch_target & ~32'd3);
        end else begin
          if (imem_req_valid) check32("fetch_addr", imem_addr, exp_fetch);
          if (imem_req_valid && imem_req_ready) begin
            exp_fetch += 32'd4;
            acc_count++;
            acc_epoch++;
          end
          if (instr_valid && instr_ready) begin
            void'(exp_q.pop_front());
            exp_q.push_back(exp_gen);
            exp_gen += 32'd4;
            hs_count++;
            hs_epoch++;
          end
        end
        prev_rst      = 1'b0;
        prev_br       = branch_valid;
        prev_req_wait = imem_req_valid && !imem_req_ready && !branch_valid;
      end
    end
  end

  // ---------------- wrap-around instance: memory and checker ----------------
  initial begin
    logic pend2;
    logic [31:0] pend2_addr, exp2_fetch, exp2_pc;
    int nacc, nhs;
    pend2 = 1'b0; pend2_addr = 32'h0; nacc = 0; nhs = 0;
    exp2_fetch = WRAP_PC; exp2_pc = WRAP_PC;
    w2_rsp_valid = 1'b0; w2_rsp_data = 32'h0;
    forever begin
      @(negedge clk);
      w2_rsp_valid = pend2;
      w2_rsp_data  = pend2 ? mem_word(pend2_addr) : 32'h0;
      pend2 = 1'b0;
      #3;
      if (rst) begin
        nacc = 0; nhs = 0; exp2_fetch = WRAP_PC; exp2_pc = WRAP_PC;
      end else begin
        if (w2_req_valid) begin
          pend2 = 1'b1;
          pend2_addr = w2_addr;
          if (nacc < 4) check32("wrap_addr", w2_addr, exp2_fetch);
          exp2_fetch += 32'd4;
          nacc++;
        end
        if (w2_instr_valid && nhs < 4) begin
          check32("wrap_pc", w2_pc, exp2_pc);
          check32("wrap_pc8", w2_pc8, exp2_pc + 32'd8);
          check32("wrap_data", w2_data, mem_word(exp2_pc));
          exp2_pc += 32'd4;
          nhs++;
          wrap_checks++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    branch_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #4;
    check32("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check32("rst_addr", imem_addr, RESET_PC);
    check32("rst_instr_valid", 32'(instr_valid), 32'd0);
    check32("rst_instr_data", instr_data, 32'd0);
    check32("rst_instr_pc", instr_pc, 32'd0);
    check32("rst_instr_pc8", instr_pc8, 32'd8);
    check32("rst_state", 32'(dbg_state), 32'(S_BOOT));
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int h0, a0;
    bit found;
    imem_req_ready = 1'b0; branch_valid = 1'b0; branch_target = 32'h0;
    halt = 1'b0; instr_ready = 1'b0;
    pulse_reset();

    // streaming: 1-cycle memory, decode always ready
    imem_req_ready = 1'b1; instr_ready = 1'b1; lat_extra = 0;
    cycles(8);
    h0 = hs_count;
    cycles(10);
    check32("stream_rate", 32'(hs_count - h0), 32'd10);

    // branch landing on a cycle with a response and a decode handshake
    @(negedge clk);
    branch_valid = 1'b1; branch_target = 32'h0000_0203;
    #4;
    check32("coincide_setup", 32'(imem_rsp_valid && instr_valid && instr_ready), 32'd1);
    @(negedge clk);
    branch_valid = 1'b0;
    cycles(6);

    // backpressure: decode stalled, only DEPTH fetches may issue
    @(negedge clk);
    instr_ready = 1'b0; branch_valid = 1'b1; branch_target = 32'h0000_1000;
    a0 = acc_count;
    @(negedge clk);
    branch_valid = 1'b0;
    cycles(12);
    check32("bp_accepts", 32'(acc_count - a0), 32'(DEPTH));
    #4;
    check32("bp_req_valid", 32'(imem_req_valid), 32'd0);
    check32("bp_head_pc", instr_pc, 32'h0000_1000);

    // branch with two fetches in flight
    @(negedge clk);
    instr_ready = 1'b1; lat_extra = 6;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      #4;
      if (pend_q.size() == 2) found = 1'b1;
    end
    check32("two_in_flight_wait", 32'(found), 32'd1);
    @(negedge clk);
    branch_valid = 1'b1; branch_target = 32'h0000_0100;
    @(negedge clk);
    branch_valid = 1'b0; lat_extra = 0;
    #4;
    check32("br_in_flight", 32'(br_pend), 32'd2);
    cycles(20);
    check32("br_progress", 32'(hs_epoch > 0), 32'd1);

    // halt with a fetch outstanding, branch while halted, release
    lat_extra = 2;
    cycles(3);
    @(negedge clk);
    halt = 1'b1;
    cycles(10);
    #4;
    check32("halt_state", 32'(dbg_state), 32'(S_HALT));
    check32("halt_req_valid", 32'(imem_req_valid), 32'd0);
    check32("halt_drained", 32'(instr_valid), 32'd0);
    check32("halt_landed", 32'(acc_epoch), 32'(hs_epoch));
    @(negedge clk);
    branch_valid = 1'b1; branch_target = 32'h0000_0040;
    @(negedge clk);
    branch_valid = 1'b0;
    #4;
    check32("halt_branch_state", 32'(dbg_state), 32'(S_HALT));
    @(negedge clk);
    halt = 1'b0;
    a0 = acc_count;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (acc_count > a0) found = 1'b1;
    end
    check32("halt_release_fetch", 32'(found), 32'd1);

    // reset in the middle of a stream
    lat_extra = 0;
    cycles(5);
    pulse_reset();

    // randomized traffic
    lat_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      branch_valid   = ($urandom_range(0, 19) == 0);
      branch_target  = $urandom();
      if ($urandom_range(0, 49) == 0) halt = ~halt;
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    rst = 1'b0; branch_valid = 1'b0; halt = 1'b0;
    cycles(10);
    check32("activity", 32'(hs_count > 100), 32'd1);
    check32("wrap_seen", 32'(wrap_checks >= 4), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
